// File: rtl/mem_line_ctrl.sv
// Main-memory line controller: serializes 4-word line fills and write-backs
// onto a single-port word memory with LAT-cycle access slots.
module mem_line_ctrl #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int LAT    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_rw,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [4*WORD_W-1:0] req_data,
  output logic                resp_ready,
  output logic [4*WORD_W-1:0] resp_data,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic [WORD_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     rw_q, rw_d;
  logic [ADDR_W-3:0]        base_q, base_d;
  logic [3:0][WORD_W-1:0]   wdata_q, wdata_d;
  logic [3:0][WORD_W-1:0]   line_q, line_d;
  logic [4*WORD_W-1:0]      resp_data_q, resp_data_d;
  logic [1:0]               w_q, w_d;
  logic [3:0]               c_q, c_d;
  logic                     accept;

  // Low address bits select a word within the line and are replaced by w.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      line_q      <= '0;
      resp_data_q <= '0;
      w_q         <= 2'd0;
      c_q         <= 4'd0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      line_q      <= line_d;
      resp_data_q <= resp_data_d;
      w_q         <= w_d;
      c_q         <= c_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    line_d      = line_q;
    resp_data_d = resp_data_q;
    w_d         = w_q;
    c_d         = c_q;
    accept      = 1'b0;
    case (state_q)
      IDLE:   accept = req_valid;
      ACCESS: begin
        if (c_q == 4'(LAT-1)) begin
          if (!rw_q) begin
            line_d[w_q] = mem_rdata;
            // Publish the whole line together with its final word.
            if (w_q == 2'd3) resp_data_d = {mem_rdata, line_q[2:0]};
          end
          if (w_q == 2'd3) begin
            state_d = DONE;
          end else begin
            w_d = w_q + 2'd1;
            c_d = 4'd0;
          end
        end else begin
          c_d = c_q + 4'd1;
        end
      end
      DONE: begin
        accept  = req_valid;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = ACCESS;
      rw_d    = req_rw;
      base_d  = req_addr[ADDR_W-1:2];
      wdata_d = req_data;
      w_d     = 2'd0;
      c_d     = 4'd0;
    end
  end

  assign mem_en     = (state_q == ACCESS) && (c_q == 4'd0);
  assign mem_we     = mem_en && rw_q;
  assign mem_addr   = {base_q, w_q};
  assign mem_wdata  = wdata_q[w_q];
  assign resp_ready = (state_q == DONE);
  assign busy       = (state_q == ACCESS);
  assign resp_data  = resp_data_q;

endmodule

// File: doc/mem_line_ctrl.md
# mem_line_ctrl

Main-memory line controller sitting directly downstream of the direct-mapped cache controller. It accepts one-cycle line requests: a read fill, or a dirty-line write-back of 4×16-bit words. It serializes each line into word accesses on a 16-bit single-port main memory with programmable wait states. It returns a one-cycle ready pulse, plus the assembled 64-bit line on reads.

## Interface
- ADDR_W, 16, word address width
- WORD_W, 16, memory word width; line = 4*WORD_W
- LAT, 4, cycles per word access slot (legal range 2..15)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  line request strobe; sampled only when accepting
- req_rw  in  1  1 = write-back, 0 = read fill
- req_addr  in  ADDR_W  any word address in the line; bits [1:0] ignored
- req_data  in  4*WORD_W  write-back line; word i = bits [16i+15:16i]
- resp_ready  out  1  one-cycle completion pulse
- resp_data  out  4*WORD_W  assembled read line
- busy  out  1  high while a request is in flight (ACCESS state)
- mem_en  out  1  word access strobe to main memory
- mem_we  out  1  word write enable
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  WORD_W  write word
- mem_rdata  in  WORD_W  read word; valid from the cycle after mem_en with mem_we=0, held until the next mem_en

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if req_valid, latch rw, base = {req_addr[ADDR_W-1:2], 2'b00}, and req_data. Clear word index w=0 and slot counter c=0. Go to ACCESS.
- ACCESS, slot cycle c=0:
  - mem_en=1, mem_we=rw, mem_addr=base+w.
  - mem_wdata = latched word w.
  - mem_en=0 for all other c.
- ACCESS, c=LAT-1:
  - On a read, capture mem_rdata into line bits [16w+15:16w].
  - If w=3, go to DONE; else w++, c=0.
- c and w are wrapping counters, 4 and 2 bits wide respectively. base+w never carries out of the line.
- DONE: resp_ready=1 for exactly this cycle.
  - On a read, resp_data shows the newly assembled line in this cycle.
  - If req_valid is high in DONE, accept the new request exactly as in IDLE and go to ACCESS. This covers the cache's write-back→allocate back-to-back request.
  - Otherwise go to IDLE.
- req_valid in ACCESS is ignored; the request is dropped.
- resp_data holds the last completed read line. A write-back never alters it.
- Latched req_data is used, so the upstream may change req_data after acceptance.

## Timing
- Reset values: state=IDLE, resp_ready=0, busy=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_data=0, w=0, c=0.
- Request accepted at cycle T:
  - ACCESS occupies cycles T+1 .. T+4*LAT.
  - DONE, and the resp_ready pulse, occur at T+4*LAT+1.
  - With LAT=4 this is 17 cycles after acceptance.
- mem_en pulses at T+1, T+1+LAT, T+1+2*LAT, T+1+3*LAT.
- Back-to-back request accepted in DONE: the next mem_en is at DONE+1. No idle cycle is inserted.
- busy=1 exactly in ACCESS cycles.
- Outputs are registered or decoded from state only. Nothing combinational depends on req_*.
- rst asserted mid-operation aborts the transfer:
  - Next cycle: IDLE, mem_en=0, no resp_ready.
  - resp_data returns to 0.
  - Any partial write remains in memory.

## Test plan
- Read fill:
  - Stimulus: memory words 0x0040..0x0043 = 1111,2222,3333,4444; req_valid with rw=0, addr=0x0042 at cycle 0.
  - Required: mem_addr 0x0040..0x0043 at cycles 1,5,9,13; resp_ready only at cycle 17; resp_data=0x4444_3333_2222_1111.
- Write-back:
  - Stimulus: rw=1, addr=0x0081, req_data=0xDDDD_CCCC_BBBB_AAAA; change req_data after acceptance.
  - Required: mem_we=1 writes AAAA..DDDD to 0x0080..0x0083 (latched values); resp_ready at cycle 17; resp_data unchanged.
- Back-to-back:
  - Stimulus: write-back, then req_valid with rw=0 presented in the DONE cycle.
  - Required: read mem_en starts the next cycle; second resp_ready exactly 17 cycles after the first.
- Dropped request:
  - Stimulus: req_valid pulsed at cycle 6 of an active read.
  - Required: no extra accesses; exactly one resp_ready.
- Reset mid-transfer:
  - Stimulus: rst at cycle 7 of a read.
  - Required: next cycle mem_en=0, busy=0, resp_ready never pulses, resp_data=0; a fresh read afterwards completes normally.
- LAT=2:
  - Stimulus: read with LAT=2.
  - Required: mem_en at cycles 1,3,5,7; resp_ready at cycle 9.
